// File: rtl/muldiv_if.sv
// Bundle of EX-stage signals between the pipeline (master) and muldiv_unit (slave).
// The pipeline drives the instruction and operands; the unit returns stall/done and HI/LO.
interface muldiv_if #(
   parameter int WIDTH = 32
) ();
   logic             en;
   logic             flush;
   logic [5:0]       funct;
   logic [WIDTH-1:0] operand_a;
   logic [WIDTH-1:0] operand_b;
   logic             stall;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output en, flush, funct, operand_a, operand_b,
      input  stall, done, hi, lo
   );

   modport slave (
      input  en, flush, funct, operand_a, operand_b,
      output stall, done, hi, lo
   );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: owns HI/LO and executes MULT/MULTU/DIV/DIVU/MTHI/MTLO.
// Multiply and divide run as WIDTH radix-2 iterations on a 2*WIDTH accumulator
// followed by a sign-fix cycle; the pipeline is held through `stall` meanwhile.
// Optional macro MULDIV_FAST_MUL_EN: MULT/MULTU use a single-cycle multiplier
// and write HI/LO on the accept edge; divide stays iterative.
module muldiv_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic     clk,
   input  logic     rst,
   muldiv_if.slave  bus
);

   typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX, S_DONE} state_t;

   localparam logic [5:0] F_MTHI = 6'h11;
   localparam logic [5:0] F_MTLO = 6'h13;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   // Multiply: {partial product high, multiplier shifting out low}.
   // Divide:   {partial remainder, dividend shifting into quotient}.
   logic [2*WIDTH-1:0] acc_q, acc_d;
   // Multiplicand magnitude (multiply) or divisor magnitude (divide).
   logic [WIDTH-1:0]   m_q, m_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               is_div_q, is_div_d;
   logic               sa_q, sa_d;
   logic               sb_q, sb_d;
   logic               dz_q, dz_d;

   // Instruction decode and operand conditioning
   logic               is_md;
   logic               op_signed;
   logic               op_div;
   logic               accept;
   logic               div_zero;
   logic               neg_a, neg_b;
   logic [WIDTH-1:0]   abs_a, abs_b;

   assign is_md     = (bus.funct[5:2] == 4'b0110);
   assign op_signed = ~bus.funct[0];
   assign op_div    = bus.funct[1];
   assign accept    = (state_q == S_IDLE) && bus.en && is_md && !bus.flush;
   assign div_zero  = op_div && (bus.operand_b == '0);
   assign neg_a     = op_signed && bus.operand_a[WIDTH-1];
   assign neg_b     = op_signed && bus.operand_b[WIDTH-1];
   // 0x80000000 negates to itself, which is the correct unsigned magnitude.
   assign abs_a     = neg_a ? (-bus.operand_a) : bus.operand_a;
   assign abs_b     = neg_b ? (-bus.operand_b) : bus.operand_b;

`ifdef MULDIV_FAST_MUL_EN
   // Sign/zero-extend to 2*WIDTH so a single truncated product covers both MULT and MULTU.
   logic [2*WIDTH-1:0] ext_a, ext_b, fast_prod;
   assign ext_a     = {{WIDTH{neg_a}} | {WIDTH{1'b0}}, bus.operand_a} |
                      {{WIDTH{op_signed & bus.operand_a[WIDTH-1]}}, {WIDTH{1'b0}}};
   assign ext_b     = {{WIDTH{op_signed & bus.operand_b[WIDTH-1]}}, bus.operand_b};
   assign fast_prod = ext_a * ext_b;
`endif

   // One shift-add multiply step: add multiplicand when the outgoing multiplier bit is set.
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_step;
   assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, m_q} : '0);
   assign mul_step = {mul_sum, acc_q[WIDTH-1:1]};

   // One restoring divide step: shift in the next dividend bit, subtract if it fits.
   logic [WIDTH:0]     rem_shift;
   logic               div_ge;
   logic [WIDTH-1:0]   rem_sub;
   logic [WIDTH-1:0]   div_rem;
   logic [2*WIDTH-1:0] div_step;
   assign rem_shift = acc_q[2*WIDTH-1:WIDTH-1];
   assign div_ge    = (rem_shift >= {1'b0, m_q});
   // True difference is below the divisor, so WIDTH bits suffice.
   assign rem_sub   = rem_shift[WIDTH-1:0] - m_q;
   assign div_rem   = div_ge ? rem_sub : rem_shift[WIDTH-1:0];
   assign div_step  = {div_rem, acc_q[WIDTH-2:0], div_ge};

   // Sign correction applied in FIX
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix;
   assign prod_fix = (sa_q ^ sb_q) ? (-acc_q) : acc_q;
   assign quo_fix  = (sa_q ^ sb_q) ? (-acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
   assign rem_fix  = sa_q ? (-acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         m_q      <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         is_div_q <= 1'b0;
         sa_q     <= 1'b0;
         sb_q     <= 1'b0;
         dz_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         m_q      <= m_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         is_div_q <= is_div_d;
         sa_q     <= sa_d;
         sb_q     <= sb_d;
         dz_q     <= dz_d;
      end
   end

   // Next-state logic; flush returns to IDLE from anywhere
   always_comb begin
      state_d = state_q;
      if (bus.flush) begin
         state_d = S_IDLE;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (accept) begin
                  if (div_zero) begin
                     state_d = S_FIX;
`ifdef MULDIV_FAST_MUL_EN
                  end else if (!op_div) begin
                     state_d = S_DONE;
`endif
                  end else begin
                     state_d = S_ITER;
                  end
               end
            end
            S_ITER:  if (cnt_q == LAST_CNT) state_d = S_FIX;
            S_FIX:   state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Datapath next values: operand latch, iteration, HI/LO writes
   always_comb begin
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      m_d      = m_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      is_div_d = is_div_q;
      sa_d     = sa_q;
      sb_d     = sb_q;
      dz_d     = dz_q;
      if (bus.flush) begin
         cnt_d = '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               cnt_d = '0;
               if (accept) begin
                  is_div_d = op_div;
                  sa_d     = neg_a;
                  sb_d     = neg_b;
                  dz_d     = div_zero;
                  if (op_div) begin
                     // Divide-by-zero keeps the raw dividend so FIX can return it untouched.
                     acc_d = {{WIDTH{1'b0}}, (div_zero ? bus.operand_a : abs_a)};
                     m_d   = abs_b;
                  end else begin
                     acc_d = {{WIDTH{1'b0}}, abs_b};
                     m_d   = abs_a;
`ifdef MULDIV_FAST_MUL_EN
                     hi_d  = fast_prod[2*WIDTH-1:WIDTH];
                     lo_d  = fast_prod[WIDTH-1:0];
`endif
                  end
               end else if (bus.en && bus.funct == F_MTHI) begin
                  hi_d = bus.operand_a;
               end else if (bus.en && bus.funct == F_MTLO) begin
                  lo_d = bus.operand_a;
               end
            end
            S_ITER: begin
               acc_d = is_div_q ? div_step : mul_step;
               cnt_d = cnt_q + 1'b1;
            end
            S_FIX: begin
               if (!is_div_q) begin
                  hi_d = prod_fix[2*WIDTH-1:WIDTH];
                  lo_d = prod_fix[WIDTH-1:0];
               end else if (dz_q) begin
                  hi_d = acc_q[WIDTH-1:0];
                  lo_d = '1;
               end else begin
                  hi_d = rem_fix;
                  lo_d = quo_fix;
               end
            end
            S_DONE:  ;
            default: ;
         endcase
      end
   end

   // Outputs: stall is combinational so the accept cycle itself holds the pipeline
   always_comb begin
      bus.stall = accept || (state_q == S_ITER) || (state_q == S_FIX);
      bus.done  = (state_q == S_DONE);
      bus.hi    = hi_q;
      bus.lo    = lo_q;
   end

endmodule
